// File: rtl/heater_controller_if.sv
// ----------------------------------------------------------------------------
// heater_controller_if
// Bundles the sensor sample stream, user controls and relay/status outputs of
// the thermostat stage.
//   temperature  16  DS18B20 reading, two's complement, 1/16 degC per LSB
//   temp_valid    1  one-cycle strobe qualifying temperature
//   setpoint      7  target temperature, whole degC, unsigned
//   enable        1  level; low forces the controller to IDLE
//   heater_on     1  registered relay drive
//   fault         1  high while latched in FAULT
//   fault_code    2  00 none, 01 sensor timeout, 10 over-temperature
//   state         2  00 IDLE, 01 OFF, 10 ON, 11 FAULT
// master drives the inputs (sensor side / user); slave is the controller.
// ----------------------------------------------------------------------------
interface heater_controller_if;
    logic        [15:0] temperature;
    logic               temp_valid;
    logic        [6:0]  setpoint;
    logic               enable;
    logic               heater_on;
    logic               fault;
    logic        [1:0]  fault_code;
    logic        [1:0]  state;

    modport master (
        output temperature, temp_valid, setpoint, enable,
        input  heater_on, fault, fault_code, state
    );

    modport slave (
        input  temperature, temp_valid, setpoint, enable,
        output heater_on, fault, fault_code, state
    );
endinterface

// File: rtl/heater_controller.sv
// ----------------------------------------------------------------------------
// heater_controller
// Hysteresis thermostat driving a water-heater relay from DS18B20 samples.
// Enforces a minimum dwell between relay transitions, latches a fault on
// over-temperature or on a missing-sample watchdog timeout.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous, active-high reset
//   io_ctl  heater_controller_if.slave (samples, setpoint, enable, status)
// ----------------------------------------------------------------------------
module heater_controller #(
    parameter int HYST           = 16,
    parameter int MAX_TEMP       = 80,
    parameter int DWELL_CYCLES   = 270_000_000,
    parameter int TIMEOUT_CYCLES = 54_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    heater_controller_if.slave   io_ctl
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OFF   = 2'b01,
        ST_ON    = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [1:0]         CODE_NONE     = 2'b00;
    localparam logic [1:0]         CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0]         CODE_OVERTEMP = 2'b10;
    // Power-on conversion value of the sensor; never a real reading for us.
    localparam logic [15:0]        POR_VALUE     = 16'h0550;
    localparam logic [6:0]         SP_MAX        = 7'(MAX_TEMP - 1);
    localparam logic signed [16:0] LIMIT         = 17'(MAX_TEMP * 16);
    localparam logic signed [16:0] HYST_S        = 17'(HYST);
    localparam logic [DW_W-1:0]    DWELL_MAX     = DW_W'(DWELL_CYCLES);
    // Watchdog value one edge before it would reach TIMEOUT_CYCLES.
    localparam logic [WD_W-1:0]    WD_LAST       = WD_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [6:0] clamp_setpoint(input logic [6:0] sp);
        return (sp > SP_MAX) ? SP_MAX : sp;
    endfunction

    function automatic logic [DW_W-1:0] sat_inc_dwell(input logic [DW_W-1:0] v);
        return (v >= DWELL_MAX) ? DWELL_MAX : v + 1'b1;
    endfunction

    state_t             r_state;
    logic [1:0]         r_code;
    logic               r_heater;
    logic [DW_W-1:0]    r_dwell;
    logic [WD_W-1:0]    r_wd;

    state_t             w_state_nxt;
    logic [1:0]         w_code_nxt;
    logic               w_toggle;
    logic               w_accept;
    logic [6:0]         w_sp_eff;
    logic signed [16:0] w_temp;
    logic signed [16:0] w_sp16;
    logic signed [16:0] w_low;
    logic               w_over;
    logic               w_cold;
    logic               w_warm;
    logic               w_dwell_ok;
    logic               w_wd_expire;
    logic               w_run_now;
    logic               w_run_nxt;

    // Sample qualification and threshold arithmetic. The setpoint is clamped
    // and used in the same edge that accepts the sample.
    assign w_accept    = io_ctl.temp_valid && (io_ctl.temperature != POR_VALUE);
    assign w_sp_eff    = clamp_setpoint(io_ctl.setpoint);
    assign w_temp      = {io_ctl.temperature[15], io_ctl.temperature};
    assign w_sp16      = {6'd0, w_sp_eff, 4'd0};
    assign w_low       = w_sp16 - HYST_S;
    assign w_over      = w_accept && (w_temp >= LIMIT);
    assign w_cold      = w_temp < w_low;
    assign w_warm      = w_temp >= w_sp16;
    assign w_dwell_ok  = r_dwell >= DWELL_MAX;
    // An accepted sample in the expiry cycle rescues the watchdog.
    assign w_wd_expire = (r_wd >= WD_LAST) && !w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_toggle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_code_nxt = CODE_NONE;
                if (io_ctl.enable) w_state_nxt = ST_OFF;
            end
            ST_OFF: begin
                if (!io_ctl.enable) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_NONE;
                end else if (w_over) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_OVERTEMP;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_TIMEOUT;
                end else if (w_accept && w_cold && w_dwell_ok) begin
                    w_state_nxt = ST_ON;
                    w_toggle    = 1'b1;
                end
            end
            ST_ON: begin
                if (!io_ctl.enable) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_NONE;
                end else if (w_over) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_OVERTEMP;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = CODE_TIMEOUT;
                end else if (w_accept && w_warm && w_dwell_ok) begin
                    w_state_nxt = ST_OFF;
                    w_toggle    = 1'b1;
                end
            end
            ST_FAULT: begin
                if (!io_ctl.enable) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = CODE_NONE;
            end
        endcase
    end

    assign w_run_now = (r_state == ST_OFF) || (r_state == ST_ON);
    assign w_run_nxt = (w_state_nxt == ST_OFF) || (w_state_nxt == ST_ON);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_code   <= CODE_NONE;
            r_heater <= 1'b0;
            r_dwell  <= '0;
            r_wd     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_heater <= (w_state_nxt == ST_ON);

            // Preload on enable so the very first sample may switch the relay.
            if (r_state == ST_IDLE && w_state_nxt == ST_OFF)
                r_dwell <= DWELL_MAX;
            else if (w_toggle)
                r_dwell <= '0;
            else
                r_dwell <= sat_inc_dwell(r_dwell);

            if (w_run_now && w_run_nxt && !w_accept)
                r_wd <= r_wd + 1'b1;
            else
                r_wd <= '0;
        end
    end

    assign io_ctl.heater_on  = r_heater;
    assign io_ctl.fault      = (r_state == ST_FAULT);
    assign io_ctl.fault_code = r_code;
    assign io_ctl.state      = r_state;

endmodule

// File: tb/tb_heater_controller.sv
// ----------------------------------------------------------------------------
// tb_heater_controller
// Directed bench for heater_controller with HYST=16, MAX_TEMP=80,
// DWELL_CYCLES=8, TIMEOUT_CYCLES=50. Expected status is queued when a step is
// driven and popped and compared once the step's clock edge has passed.
// ----------------------------------------------------------------------------
module tb_heater_controller;

    logic clk;
    logic rst;

    heater_controller_if bus ();

    heater_controller #(
        .HYST           (16),
        .MAX_TEMP       (80),
        .DWELL_CYCLES   (8),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_OFF   = 2'b01;
    localparam logic [1:0] S_ON    = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [1:0] code;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_pop();
        exp_t e;
        logic exp_heat;
        logic exp_fault;
        e         = sbq.pop_front();
        exp_heat  = (e.st == S_ON);
        exp_fault = (e.st == S_FAULT);

        checks++;
        assert (bus.state === e.st) else begin
            errors++;
            $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            $error("%s state mismatch", e.tag);
        end
        checks++;
        assert (bus.heater_on === exp_heat) else begin
            errors++;
            $display("FAIL %s heater_on got %0b want %0b", e.tag, bus.heater_on, exp_heat);
            $error("%s heater_on mismatch", e.tag);
        end
        checks++;
        assert (bus.fault === exp_fault) else begin
            errors++;
            $display("FAIL %s fault got %0b want %0b", e.tag, bus.fault, exp_fault);
            $error("%s fault mismatch", e.tag);
        end
        checks++;
        assert (bus.fault_code === e.code) else begin
            errors++;
            $display("FAIL %s fault_code got %0d want %0d", e.tag, bus.fault_code, e.code);
            $error("%s fault_code mismatch", e.tag);
        end
    endtask

    // Called at a negedge: strobe one sample through the next posedge, check.
    task automatic sample(input logic [15:0] t, input string tag,
                          input logic [1:0] st, input logic [1:0] code);
        bus.temperature = t;
        bus.temp_valid  = 1'b1;
        sbq.push_back('{tag: tag, st: st, code: code});
        @(negedge clk);
        bus.temp_valid  = 1'b0;
        check_pop();
    endtask

    // Advance n clock edges with no strobe.
    task automatic idle(input int n);
        bus.temp_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Strobe the discarded power-on value for n edges, unchecked.
    task automatic por_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            bus.temperature = 16'h0550;
            bus.temp_valid  = 1'b1;
            @(negedge clk);
        end
        bus.temp_valid = 1'b0;
    endtask

    task automatic expect_now(input string tag, input logic [1:0] st,
                              input logic [1:0] code);
        sbq.push_back('{tag: tag, st: st, code: code});
        check_pop();
    endtask

    initial begin
        rst             = 1'b1;
        bus.temperature = 16'h0000;
        bus.temp_valid  = 1'b0;
        bus.setpoint    = 7'd60;
        bus.enable      = 1'b0;
        repeat (3) @(negedge clk);
        expect_now("reset", S_IDLE, 2'b00);
        rst = 1'b0;

        // Enable and first sample switches immediately thanks to the preload.
        bus.enable = 1'b1;
        idle(1);
        expect_now("enable_off", S_OFF, 2'b00);
        sample(16'h0320, "heat_on_50C", S_ON, 2'b00);

        // Dwell blocks an early turn-off, then hysteresis around 60 degC.
        idle(1);
        sample(16'h03C0, "dwell_block", S_ON, 2'b00);
        sample(16'h03BF, "below_sp_stay_on", S_ON, 2'b00);
        idle(10);
        sample(16'h03C0, "off_at_sp", S_OFF, 2'b00);
        idle(10);
        sample(16'h03B1, "in_band_stay_off", S_OFF, 2'b00);
        sample(16'h03AF, "below_low_on", S_ON, 2'b00);

        // 85 degC power-on value is discarded even though it exceeds the limit.
        sample(16'h0550, "discard_por", S_ON, 2'b00);

        // Over-temperature latches, ignores samples and the watchdog.
        sample(16'h0500, "overtemp", S_FAULT, 2'b10);
        sample(16'h0320, "fault_latched", S_FAULT, 2'b10);
        idle(60);
        expect_now("fault_no_timeout", S_FAULT, 2'b10);
        bus.enable = 1'b0;
        idle(1);
        expect_now("fault_exit", S_IDLE, 2'b00);

        // Timeout exactly 50 edges after the last accepted sample.
        bus.enable = 1'b1;
        idle(1);
        expect_now("reenable", S_OFF, 2'b00);
        sample(16'h03C0, "last_accepted", S_OFF, 2'b00);
        por_strobes(48);
        sample(16'h0550, "pre_timeout", S_OFF, 2'b00);
        sample(16'h0550, "timeout", S_FAULT, 2'b01);
        bus.enable = 1'b0;
        idle(1);
        expect_now("timeout_exit", S_IDLE, 2'b00);

        // Accepted sample in the expiry cycle wins.
        bus.enable = 1'b1;
        idle(1);
        expect_now("reenable2", S_OFF, 2'b00);
        sample(16'h03C0, "wd_start", S_OFF, 2'b00);
        por_strobes(48);
        sample(16'h0550, "pre_expiry", S_OFF, 2'b00);
        sample(16'h03C0, "sample_wins", S_OFF, 2'b00);
        idle(48);
        expect_now("wd_restarted", S_OFF, 2'b00);

        // Setpoint 127 clamps to 79: low threshold 1248.
        bus.setpoint = 7'd127;
        sample(16'h04E1, "clamp_in_band", S_OFF, 2'b00);
        sample(16'h04DF, "clamp_below_low", S_ON, 2'b00);

        // Negative reading is below every threshold.
        bus.enable = 1'b0;
        idle(1);
        expect_now("disable_from_on", S_IDLE, 2'b00);
        bus.enable = 1'b1;
        idle(1);
        expect_now("reenable3", S_OFF, 2'b00);
        sample(16'hFF80, "negative_on", S_ON, 2'b00);

        // Asynchronous reset drops the relay between clock edges.
        #2 rst = 1'b1;
        #1 expect_now("async_reset", S_IDLE, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        expect_now("after_reset_idle", S_OFF, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heater_controller.md
# heater_controller

Thermostat stage directly downstream of the DS18B20 master. It consumes each completed 16-bit temperature conversion and drives the water-heater relay with hysteresis around a user setpoint. Minimum on and off dwell times protect the relay. A sensor-timeout watchdog and an over-temperature limit latch a fault that forces the heater off.

## Interface
- `HYST`, 16: hysteresis band in 1/16 °C LSBs; heat turns on below `setpoint×16 − HYST`.
- `MAX_TEMP`, 80: over-temperature limit in whole °C.
- `DWELL_CYCLES`, 270_000_000: minimum clock cycles between relay transitions (10 s at 27 MHz).
- `TIMEOUT_CYCLES`, 54_000_000: maximum cycles between accepted samples before a timeout fault (2 s).
- `CLK`  in  1  system clock (27 MHz on board).
- `RST`  in  1  asynchronous, active-high reset.
- `TEMPERATURE`  in  16  DS18B20 reading, two's complement, 1/16 °C per LSB.
- `TEMP_VALID`  in  1  one-cycle strobe; `TEMPERATURE` is valid in this cycle.
- `SETPOINT`  in  7  target temperature in whole °C (unsigned).
- `ENABLE`  in  1  level; 0 forces IDLE.
- `HEATER_ON`  out  1  relay drive, registered.
- `FAULT`  out  1  high while in FAULT.
- `FAULT_CODE`  out  2  00 none, 01 sensor timeout, 10 over-temperature; held until FAULT exits.
- `STATE`  out  2  00 IDLE, 01 OFF, 10 ON, 11 FAULT.

## Operation
- **Reset values:** IDLE, `HEATER_ON`=0, `FAULT`=0, `FAULT_CODE`=00, `STATE`=00, both counters 0.
- **Accepted sample:** a `TEMP_VALID` cycle where `TEMPERATURE` ≠ 16'h0550.
  - 16'h0550 is the sensor's 85 °C power-on value. It is discarded: no state effect and no watchdog reset.
- **Setpoint capture:** on each accepted sample, the effective setpoint is registered as min(`SETPOINT`, `MAX_TEMP`−1).
  - Thresholds use the freshly registered value.
- **Arithmetic:** 17-bit signed.
  - sp16 = effective setpoint×16.
  - Low threshold = sp16 − `HYST`.
  - Limit = `MAX_TEMP`×16.
  - `TEMPERATURE` is sign-extended; negative readings compare below every threshold.
- **States** (priority order at every edge: RST > `ENABLE`=0 > over-temperature > timeout > regulation):
  - **IDLE:** heater off; watchdog held at 0. On `ENABLE`=1, go to OFF with the dwell counter preloaded to `DWELL_CYCLES`, so the first sample can switch immediately.
  - **OFF:**
    - Accepted sample with temp ≥ limit → FAULT, code 10.
    - Accepted sample with temp < low threshold and dwell ≥ `DWELL_CYCLES` → ON.
    - Otherwise stay in OFF.
  - **ON:**
    - Accepted sample with temp ≥ limit → FAULT, code 10, immediately (dwell ignored).
    - Accepted sample with temp ≥ sp16 and dwell ≥ `DWELL_CYCLES` → OFF.
    - Otherwise stay in ON.
  - **Timeout (OFF or ON):** watchdog reaching `TIMEOUT_CYCLES` → FAULT, code 01.
  - **FAULT:** heater off. Latched; exits only to IDLE when `ENABLE`=0. `FAULT_CODE` clears on exit.
- **Dwell counter:**
  - Reset to 0 on every OFF↔ON transition.
  - Increments each cycle otherwise, saturating at `DWELL_CYCLES`.
- **Watchdog:**
  - Cleared on every accepted sample.
  - Increments each cycle in OFF/ON.
  - Held at 0 in IDLE and FAULT.
- **Hysteresis blocking:** a sample that meets a threshold while dwell is unsatisfied is ignored. The next accepted sample re-evaluates; no pending-request memory.

## Timing
- `HEATER_ON`, `STATE`, `FAULT` and `FAULT_CODE` all update at the clock edge that samples `TEMP_VALID`. They are visible 1 cycle after the strobe.
- Timeout: the fault asserts at the edge where the watchdog count equals `TIMEOUT_CYCLES`, measured from the accepted sample.
  - If an accepted sample arrives in that same cycle, the sample wins: watchdog cleared, no fault.
- `ENABLE` falling: IDLE and `HEATER_ON`=0 at the next edge, regardless of dwell.
- `RST` asserted mid-operation: `HEATER_ON` drops asynchronously.
- `TEMP_VALID` while in IDLE or FAULT is ignored.
- Back-to-back `TEMP_VALID` strobes are legal; each is processed independently.

## Test plan
Bench parameters: `HYST`=16, `MAX_TEMP`=80, `DWELL_CYCLES`=8, `TIMEOUT_CYCLES`=50.
- **Reset/enable:** RST, then `ENABLE`=1, `SETPOINT`=60, sample 16'h0320 (50 °C) → `STATE`=10 and `HEATER_ON`=1 one cycle after the strobe.
- **Hysteresis:** in ON, sample 16'h03BF (59.94 °C) → stays ON; 16'h03C0 (60 °C) after dwell → OFF. Then 16'h03B1 → stays OFF; 16'h03AF (58.94 °C) → ON.
- **Dwell:** in ON, sample 16'h03C0 two cycles after entering ON → no change. Repeat the sample after cycle 8 → OFF.
- **Over-temperature:** in ON, sample 16'h0500 (80 °C) → `STATE`=11, `FAULT_CODE`=10, `HEATER_ON`=0 next cycle. Further samples have no effect until `ENABLE`=0 → IDLE, code 00.
- **Timeout and discard:** only 16'h0550 strobes for 60 cycles → `FAULT_CODE`=01 exactly 50 cycles after the last accepted sample. Separately, an accepted sample on cycle 50 → no fault.
- **Edge cases:** `SETPOINT`=127 clamps the effective setpoint to 79. Sample 16'hFF80 (−8 °C) → heat on. `RST` pulse while ON → `HEATER_ON`=0 without waiting for a clock edge.
